// File: rtl/ex_muldiv_pkg.sv
// Shared constants, FSM encoding and decode helpers for the iterative RV32M unit.
// Pure definitions: no logic, no latency, no flow control.
package ex_muldiv_pkg;

    localparam int MD_XLEN        = 32;
    localparam int MD_CNT_W       = 5;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Decode used by EX to form the start level from the ID/EX instruction word.
    function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage request/response bundle between the pipeline (master) and the M unit (slave).
// Wires only; stall_req is the backpressure path back into PC, IF/ID and ID/EX.
interface ex_muldiv_if;

    logic                                      start;
    logic [2:0]                                funct3;
    logic [ex_muldiv_pkg::MD_XLEN-1:0]         rs1_data;
    logic [ex_muldiv_pkg::MD_XLEN-1:0]         rs2_data;
    logic [ex_muldiv_pkg::REG_ADDR_WIDTH-1:0]  rd_in;
    logic                                      flush;
    logic                                      stall_req;
    logic                                      busy;
    logic                                      done;
    logic [ex_muldiv_pkg::MD_XLEN-1:0]         result;
    logic [ex_muldiv_pkg::REG_ADDR_WIDTH-1:0]  rd_out;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in, flush,
        input  stall_req, busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in, flush,
        output stall_req, busy, done, result, rd_out
    );

endinterface

// File: rtl/ex_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
// Purely combinational (zero latency); no flow control.
module ex_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {2'b00, dvsr_i};
        // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
        if (!diff[XLEN+1]) begin
            rem_o = diff[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: 33 cycles accept-to-done (1 for div-by-zero/overflow).
// Holds the pipeline through stall_req while accepting and computing; done is a one-cycle pulse.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave md
);

    md_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [XLEN-1:0]           opa_q, opa_d;
    logic [2*XLEN-1:0]         prod_q, prod_d;
    logic [XLEN:0]             rem_q, rem_d;
    logic [XLEN-1:0]           quo_q, quo_d;
    logic                      qneg_q, qneg_d;
    logic                      rneg_q, rneg_d;
    logic [XLEN-1:0]           result_q, result_d;
    logic                      done_q, done_d;

    logic            sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            accept, div_zero, div_ovf;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] prod_step, prod_fin;
    logic [XLEN:0]   rem_step;
    logic [XLEN-1:0] quo_step, quo_fin, rem_fin;

    ex_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (opa_q),
        .rem_o  (rem_step),
        .quo_o  (quo_step)
    );

    always_comb begin
        sgn1 = (md.funct3 == FUNCT3_MULH) || (md.funct3 == FUNCT3_MULHSU) ||
               (md.funct3 == FUNCT3_DIV)  || (md.funct3 == FUNCT3_REM);
        sgn2 = (md.funct3 == FUNCT3_MULH) || (md.funct3 == FUNCT3_DIV) ||
               (md.funct3 == FUNCT3_REM);
        neg1 = sgn1 & md.rs1_data[XLEN-1];
        neg2 = sgn2 & md.rs2_data[XLEN-1];
        mag1 = neg1 ? -md.rs1_data : md.rs1_data;
        mag2 = neg2 ? -md.rs2_data : md.rs2_data;
        div_zero = (md.rs2_data == '0);
        div_ovf  = ((md.funct3 == FUNCT3_DIV) || (md.funct3 == FUNCT3_REM)) &&
                   (md.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (md.rs2_data == '1);
        accept   = (state_q == MD_IDLE) && md.start && !md.flush;
    end

    always_comb begin
        // Shift-add: the low half of prod_q starts as the multiplier and drains out the bottom.
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opa_q};
        prod_step = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
        prod_fin  = qneg_q ? -prod_step : prod_step;
        quo_fin   = qneg_q ? -quo_step : quo_step;
        rem_fin   = rneg_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opa_d    = opa_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    op_d = md.funct3;
                    rd_d = md.rd_in;
                    if (md.funct3[2] && (div_zero || div_ovf)) begin
                        if (div_zero)
                            result_d = md.funct3[1] ? md.rs1_data : '1;
                        else
                            result_d = md.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        done_d  = 1'b1;
                        state_d = MD_DONE;
                    end else begin
                        cnt_d   = '0;
                        opa_d   = md.funct3[2] ? mag2 : mag1;
                        prod_d  = {{XLEN{1'b0}}, mag2};
                        rem_d   = '0;
                        quo_d   = mag1;
                        qneg_d  = neg1 ^ neg2;
                        rneg_d  = neg1;
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (md.flush) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[2]) begin
                        rem_d = rem_step;
                        quo_d = quo_step;
                    end else begin
                        prod_d = prod_step;
                    end
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        if (op_q[2])
                            result_d = op_q[1] ? rem_fin : quo_fin;
                        else
                            result_d = (op_q == FUNCT3_MUL) ? prod_fin[XLEN-1:0]
                                                            : prod_fin[2*XLEN-1:XLEN];
                        done_d  = 1'b1;
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            opa_q    <= opa_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign md.stall_req = accept || (state_q == MD_CALC);
    assign md.busy      = (state_q != MD_IDLE);
    assign md.done      = done_q;
    assign md.result    = result_q;
    assign md.rd_out    = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus randomized checks of ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] last_exp = 32'h0;

    always #5 clk = ~clk;

    ex_muldiv_if mif ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .md  (mif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = 32'h0;
        case (f)
            3'b000: begin pu = ua * ub; r = pu[31:0]; end
            3'b001: begin ps = sa * sb; r = ps[63:32]; end
            3'b010: begin ps = sa * longint'(ub); r = ps[63:32]; end
            3'b011: begin pu = ua * ub; r = pu[63:32]; end
            3'b100: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'b101: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Called one time unit after a rising edge; leaves the bench just after the IDLE edge.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        bit          special;
        int          lat;
        int          stalls;
        exp     = ref_md(f, a, b);
        special = f[2] && ((b == 32'h0) ||
                  (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        mif.start    = 1'b1;
        mif.flush    = 1'b0;
        mif.funct3   = f;
        mif.rs1_data = a;
        mif.rs2_data = b;
        mif.rd_in    = rd;
        #1;
        lat    = 0;
        stalls = 0;
        while (mif.done !== 1'b1 && lat < 100) begin
            if (mif.stall_req === 1'b1) stalls++;
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                // Operands must come from the latched copies once accepted.
                mif.rs1_data = $urandom;
                mif.rs2_data = $urandom;
            end
        end
        chk({tag, " latency"}, 32'(lat), special ? 32'd1 : 32'd33);
        chk({tag, " stall_cycles"}, 32'(stalls), special ? 32'd1 : 32'd33);
        chk({tag, " result"}, mif.result, exp);
        chk({tag, " rd_out"}, 32'(mif.rd_out), 32'(rd));
        chk({tag, " stall_in_done"}, 32'(mif.stall_req), 32'd0);
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        chk({tag, " done_drop"}, 32'(mif.done), 32'd0);
        chk({tag, " idle_busy"}, 32'(mif.busy), 32'd0);
        chk({tag, " result_hold"}, mif.result, exp);
        last_exp = exp;
    endtask

    initial begin
        mif.start    = 1'b0;
        mif.flush    = 1'b0;
        mif.funct3   = 3'b000;
        mif.rs1_data = 32'h0;
        mif.rs2_data = 32'h0;
        mif.rd_in    = 5'd0;

        // Reset state
        #1;
        chk("rst busy", 32'(mif.busy), 32'd0);
        chk("rst done", 32'(mif.done), 32'd0);
        chk("rst stall", 32'(mif.stall_req), 32'd0);
        chk("rst result", mif.result, 32'h0);
        chk("rst rd_out", 32'(mif.rd_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed arithmetic
        run_op("mul_7_m3",    3'b000, 32'd7,           32'hFFFF_FFFD, 5'd11);
        run_op("mulh_min",    3'b001, 32'h8000_0000,   32'h8000_0000, 5'd3);
        run_op("mulhu_ones",  3'b011, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 5'd4);
        run_op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF,   32'h0000_0002, 5'd5);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,   32'd2,         5'd6);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,   32'd2,         5'd7);
        run_op("divu_100_7",  3'b101, 32'd100,         32'd7,         5'd8);
        run_op("remu_100_7",  3'b111, 32'd100,         32'd7,         5'd9);

        // Special cases
        run_op("divu_by0",    3'b101, 32'd5,           32'd0,         5'd10);
        run_op("remu_by0",    3'b111, 32'd5,           32'd0,         5'd12);
        run_op("div_ovf",     3'b100, 32'h8000_0000,   32'hFFFF_FFFF, 5'd13);
        run_op("rem_ovf",     3'b110, 32'h8000_0000,   32'hFFFF_FFFF, 5'd14);

        // Flush while idle with start: nothing accepted
        mif.start    = 1'b1;
        mif.flush    = 1'b1;
        mif.funct3   = 3'b000;
        mif.rs1_data = 32'd9;
        mif.rs2_data = 32'd9;
        #1;
        chk("idle_flush stall", 32'(mif.stall_req), 32'd0);
        @(posedge clk);
        #1;
        chk("idle_flush busy", 32'(mif.busy), 32'd0);
        chk("idle_flush result", mif.result, last_exp);
        mif.start = 1'b0;
        mif.flush = 1'b0;

        // Flush at CALC cycle 10
        mif.start    = 1'b1;
        mif.funct3   = 3'b100;
        mif.rs1_data = 32'd1000;
        mif.rs2_data = 32'd7;
        mif.rd_in    = 5'd20;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("flush calc_busy", 32'(mif.busy), 32'd1);
        mif.flush = 1'b1;
        @(posedge clk);
        #1;
        mif.flush = 1'b0;
        mif.start = 1'b0;
        chk("flush busy", 32'(mif.busy), 32'd0);
        chk("flush done", 32'(mif.done), 32'd0);
        chk("flush result", mif.result, last_exp);
        run_op("after_flush", 3'b101, 32'd100, 32'd7, 5'd21);

        // Asynchronous reset mid-CALC
        mif.start    = 1'b1;
        mif.funct3   = 3'b000;
        mif.rs1_data = 32'd5;
        mif.rs2_data = 32'd6;
        mif.rd_in    = 5'd22;
        repeat (6) @(posedge clk);
        #3;
        rst       = 1'b1;
        mif.start = 1'b0;
        #1;
        chk("arst busy", 32'(mif.busy), 32'd0);
        chk("arst done", 32'(mif.done), 32'd0);
        chk("arst stall", 32'(mif.stall_req), 32'd0);
        chk("arst result", mif.result, 32'h0);
        chk("arst rd_out", 32'(mif.rd_out), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 5'd23);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 5'($urandom_range(1, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- It consumes ID/EX outputs (operands, funct3, rd) when EX decodes an M-extension instruction.
- It holds the pipeline via stall_req while computing, then presents a single-cycle result to the EX/MEM writeback path.
- Flushes from branch resolution abort an in-flight operation.

Parameters:
XLEN, 32, operand/result width (matches `REG_DATA_WIDTH)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  EX holds an M-type instruction (ID/EX.inst opcode 0110011, funct7 0000001); level, held while stalled
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  forwarded operand 1
rs2_data  input  XLEN  forwarded operand 2
rd_in  input  `REG_ADDR_WIDTH  destination register from ID/EX
flush  input  1  abort current operation (same cycle as ID_flush)
stall_req  output  1  combinational; freezes PC, IF/ID and ID/EX
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: result valid
result  output  XLEN  final result; held until the next accepted start
rd_out  output  `REG_ADDR_WIDTH  rd latched at accept

Behaviour:
- Reset (async, any state, including mid-operation):
  - State returns to IDLE; counter, accumulators, result and rd_out are cleared to 0.
  - done=0, busy=0, stall_req=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start=1 and flush=0 at edge E0, latch funct3, rd_in and operand magnitudes plus sign flags.
  - Signed operands: MULH rs1/rs2; MULHSU rs1 only; DIV/REM both.
  - Next state is CALC with cnt=0, or DONE for special cases.
- Special cases, IDLE->DONE at E0, so done is visible in the cycle after E0:
  - Divisor==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV result 0x80000000, REM result 0.
- CALC: one iteration per cycle; cnt increments each cycle; when cnt==XLEN-1, go to DONE. That is 32 iterations; DONE is entered at E32 and done is visible in the cycle after E32.
  - Multiply: radix-2 shift-add on magnitudes into a 2*XLEN product. At DONE, negate the product if the sign flags differ. MUL takes the low half; MULH/MULHSU/MULHU take the high half.
  - Divide: restoring, one quotient bit per cycle (XLEN+1-bit partial remainder). Sign fixups:
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
    - Unsigned ops apply no fixup.
- DONE:
  - done=1, stall_req=0, so the pipeline advances and ID/EX captures the next instruction.
  - result is registered and valid; next state is IDLE unconditionally.
  - A start seen in DONE belongs to the same instruction and is not re-accepted.
- Back-to-back M instructions: the IDLE after DONE accepts a new start. Minimum gap is one idle cycle; one-cycle throughput is not required.
- stall_req = (state==IDLE & start & ~flush) | (state==CALC).
  - It is low in DONE and low in IDLE without start.
- flush:
  - In CALC: next state is IDLE, no done, result unchanged.
  - In IDLE with start: nothing is accepted.
  - In DONE: done still pulses; EX/MEM discards it.
- start while in CALC is ignored; operands are taken only from the latched copies.
- All arithmetic is modulo 2^XLEN; no exceptions are raised.

Decomposition:
- Shared constants go in const.v:
  - `FUNCT3_MUL..`FUNCT3_REMU
  - M-extension `FUNCT7_MULDIV (7'b0000001)
  - FSM state encodings `MD_IDLE/`MD_CALC/`MD_DONE
- Natural sub-module: ex_divstep. It is a combinational restoring-division step: {rem, quo} plus divisor in, next {rem, quo} out. It can be reused by a future radix-4 variant.
- The multiply step stays inline.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall_req high for 33 cycles; done at cycle 33 after the accept edge; result 0xFFFFFFEB; rd_out=rd_in.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases (done in the cycle after accept, stall_req high only in the accept cycle):
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
- DIV started, flush asserted at CALC cycle 10 -> busy=0 next cycle, done never pulses, result keeps its prior value. An immediate new start is accepted normally.
- rst asserted mid-CALC (asynchronously, between edges) -> outputs zero immediately. After release, a MUL 3*4 completes with 12.
